// File: rtl/id_regfile_scoreboard.sv
// Decode-stage register file with WB write-through and a per-register load
// scoreboard that stalls consumers for LOAD_LAT cycles after a load issues.

module id_sb_entry #(
  parameter int LOAD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic clear,
  output logic busy
);
  logic [2:0] cnt;

  // A fresh load wins over the running decrement on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             cnt <= '0;
    else if (load)          cnt <= 3'(LOAD_LAT);
    else if (clear)         cnt <= '0;
    else if (cnt != 3'd0)   cnt <= cnt - 3'd1;
  end

  assign busy = (cnt != 3'd0);
endmodule

module id_regfile_scoreboard #(
  parameter  int XLEN     = 32,
  parameter  int NREG     = 32,
  parameter  int LOAD_LAT = 1,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs_addr_id,
  input  logic [AW-1:0]   rt_addr_id,
  input  logic            rs_used_id,
  input  logic            rt_used_id,
  input  logic            issue_id,
  input  logic [AW-1:0]   rd_addr_id,
  input  logic            reg_write_id,
  input  logic            mem_read_id,
  input  logic            reg_write_wb,
  input  logic [AW-1:0]   reg_write_addr_wb,
  input  logic [XLEN-1:0] reg_write_data_wb,
  output logic [XLEN-1:0] rs_data_id,
  output logic [XLEN-1:0] rt_data_id,
  output logic            z,
  output logic            stall,
  output logic            pc_if_write,
  output logic [31:0]     stall_cycles
);
  logic [NREG-1:0][XLEN-1:0] regs;
  logic [NREG-1:0]           busy;
  logic                      wbHit0, rdIsZero, accept, sbTouch;

  function automatic logic isZeroReg(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  function automatic logic [XLEN-1:0] readPort(
    input logic [AW-1:0]           a,
    input logic [NREG-1:0][XLEN-1:0] rf,
    input logic                    we,
    input logic [AW-1:0]           wa,
    input logic [XLEN-1:0]         wd
  );
    if (isZeroReg(a))       return '0;
    if (we && (wa == a))    return wd;
    return rf[a];
  endfunction

  assign wbHit0 = isZeroReg(reg_write_addr_wb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      regs <= '0;
    else if (reg_write_wb && !wbHit0) regs[reg_write_addr_wb] <= reg_write_data_wb;
  end

  // Bypass is masked in reset so reads see the cleared file immediately.
  assign rs_data_id = readPort(rs_addr_id, regs, reg_write_wb & rst_n,
                               reg_write_addr_wb, reg_write_data_wb);
  assign rt_data_id = readPort(rt_addr_id, regs, reg_write_wb & rst_n,
                               reg_write_addr_wb, reg_write_data_wb);
  assign z          = (rs_data_id == rt_data_id);

  assign stall       = rst_n & issue_id &
                       ((rs_used_id & busy[rs_addr_id]) | (rt_used_id & busy[rt_addr_id]));
  assign pc_if_write = ~stall;

  assign rdIsZero = isZeroReg(rd_addr_id);
  assign accept   = issue_id & ~stall;
  assign sbTouch  = accept & reg_write_id & ~rdIsZero;

  // ALU results forward from EX, so a non-load writer releases the entry.
  generate
    for (genvar g = 0; g < NREG; g++) begin : gSb
      logic hit;
      assign hit = sbTouch & (rd_addr_id == AW'(g));
      id_sb_entry #(.LOAD_LAT(LOAD_LAT)) uEntry (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (hit & mem_read_id),
        .clear (hit & ~mem_read_id),
        .busy  (busy[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 stall_cycles <= '0;
    else if (stall && (stall_cycles != '1))     stall_cycles <= stall_cycles + 32'd1;
  end
endmodule

// File: tb/tb_id_regfile_scoreboard.sv
// Randomized + directed bench: two DUTs (LOAD_LAT 1 and 3) share stimulus and
// are checked every cycle against a ready-time reference model.

module tb_id_regfile_scoreboard;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]   rsA, rtA, rdA, wbAddr;
  logic            rsU, rtU, issue, regWr, memRd, wbWe;
  logic [XLEN-1:0] wbData;

  logic [1:0][XLEN-1:0] rsD, rtD;
  logic [1:0][31:0]     stCnt;
  logic [1:0]           zO, stO, pcO;

  generate
    for (genvar i = 0; i < 2; i++) begin : gDut
      id_regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .LOAD_LAT(i == 0 ? 1 : 3), .ZERO_REG(1)) uDut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rs_addr_id        (rsA),
        .rt_addr_id        (rtA),
        .rs_used_id        (rsU),
        .rt_used_id        (rtU),
        .issue_id          (issue),
        .rd_addr_id        (rdA),
        .reg_write_id      (regWr),
        .mem_read_id       (memRd),
        .reg_write_wb      (wbWe),
        .reg_write_addr_wb (wbAddr),
        .reg_write_data_wb (wbData),
        .rs_data_id        (rsD[i]),
        .rt_data_id        (rtD[i]),
        .z                 (zO[i]),
        .stall             (stO[i]),
        .pc_if_write       (pcO[i]),
        .stall_cycles      (stCnt[i])
      );
    end
  endgenerate

  int nChk = 0;
  int nFail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChk++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a register is "pending" until the cycle index it becomes ready.
  logic [XLEN-1:0] mRegs [NREG];
  longint          readyAt [2][NREG];
  longint          mStall [2];
  longint          cyc = 0;

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [XLEN-1:0] mRead(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (wbWe && wbAddr == a) return wbData;
    return mRegs[a];
  endfunction

  function automatic bit mPend(input int d, input logic [AW-1:0] a);
    return (a != 0) && (cyc < readyAt[d][a]);
  endfunction

  function automatic bit mStallF(input int d);
    return issue && ((rsU && mPend(d, rsA)) || (rtU && mPend(d, rtA)));
  endfunction

  task automatic mClear();
    for (int r = 0; r < NREG; r++) begin
      mRegs[r] = '0;
      readyAt[0][r] = 0;
      readyAt[1][r] = 0;
    end
    mStall[0] = 0;
    mStall[1] = 0;
  endtask

  task automatic setId(input bit iss, input int rs, input bit rsu, input int rt, input bit rtu,
                       input int rd, input bit rw, input bit mr);
    issue = iss; rsA = AW'(rs); rsU = rsu; rtA = AW'(rt); rtU = rtu;
    rdA = AW'(rd); regWr = rw; memRd = mr;
  endtask

  task automatic setWb(input bit we, input int a, input logic [XLEN-1:0] d);
    wbWe = we; wbAddr = AW'(a); wbData = d;
  endtask

  task automatic idle();
    setId(0, 0, 0, 0, 0, 0, 0, 0);
    setWb(0, 0, '0);
  endtask

  // Called at posedge+1 with inputs set; checks at negedge, then advances the model.
  task automatic step();
    bit expSt [2];
    logic [XLEN-1:0] eRs, eRt;
    #4;
    eRs = mRead(rsA);
    eRt = mRead(rtA);
    for (int d = 0; d < 2; d++) begin
      expSt[d] = mStallF(d);
      chk($sformatf("rs_data[%0d] c%0d", d, cyc), 64'(rsD[d]), 64'(eRs));
      chk($sformatf("rt_data[%0d] c%0d", d, cyc), 64'(rtD[d]), 64'(eRt));
      chk($sformatf("z[%0d] c%0d", d, cyc), 64'(zO[d]), 64'(eRs == eRt));
      chk($sformatf("stall[%0d] c%0d", d, cyc), 64'(stO[d]), 64'(expSt[d]));
      chk($sformatf("pc_if_write[%0d] c%0d", d, cyc), 64'(pcO[d]), 64'(!expSt[d]));
      chk($sformatf("stall_cycles[%0d] c%0d", d, cyc), 64'(stCnt[d]),
          (mStall[d] > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : 64'(mStall[d]));
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (expSt[d]) mStall[d]++;
      else if (issue && regWr && rdA != 0)
        readyAt[d][rdA] = memRd ? (cyc + 1 + lat(d)) : 0;
    end
    if (wbWe && wbAddr != 0) mRegs[wbAddr] = wbData;
    cyc++;
    #1;
  endtask

  task automatic drain(input int n);
    idle();
    repeat (n) step();
  endtask

  initial begin
    idle();
    mClear();
    #2;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset stall[%0d]", d), 64'(stO[d]), 64'd0);
      chk($sformatf("reset pc_if_write[%0d]", d), 64'(pcO[d]), 64'd1);
      chk($sformatf("reset stall_cycles[%0d]", d), 64'(stCnt[d]), 64'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drain(1);

    // Write-through, then plain read on the next cycle
    setWb(1, 7, 32'hDEADBEEF); setId(0, 7, 1, 0, 0, 0, 0, 0); step();
    setWb(0, 0, '0);           setId(0, 0, 0, 7, 1, 0, 0, 0); step();

    // Register 0: writes dropped, loads never pend
    setWb(1, 0, 32'h1234); setId(0, 0, 1, 0, 1, 0, 0, 0); step();
    setWb(0, 0, '0);
    setId(1, 0, 0, 0, 0, 0, 1, 1); step();
    setId(1, 0, 1, 0, 1, 4, 1, 0); step();
    drain(2);

    // Load-use: lw r3 then add r4,r3,r2 held until accepted
    setId(1, 0, 0, 0, 0, 3, 1, 1); step();
    setId(1, 3, 1, 2, 1, 4, 1, 0); repeat (5) step();
    drain(4);

    // One unrelated instruction between load and consumer
    setId(1, 0, 0, 0, 0, 3, 1, 1); step();
    setId(1, 8, 1, 9, 1, 10, 1, 0); step();
    setId(1, 3, 1, 2, 1, 4, 1, 0); repeat (4) step();
    drain(4);

    // Pending rt not used by the consumer
    setId(1, 0, 0, 0, 0, 3, 1, 1); step();
    setId(1, 2, 1, 3, 0, 4, 1, 0); step();
    drain(4);

    // Branch compare with same-cycle WB override
    setWb(1, 1, 32'h55); step();
    setWb(1, 2, 32'h55); step();
    setWb(0, 0, '0); setId(0, 1, 1, 2, 1, 0, 0, 0); step();
    setWb(1, 2, 32'h56); step();
    drain(1);

    // Reset while a consumer of a pending r5 is stalled
    setWb(1, 5, 32'hA5A5); step();
    setWb(0, 0, '0); setId(1, 0, 0, 0, 0, 5, 1, 1); step();
    setId(1, 5, 1, 0, 0, 6, 1, 0); step();
    #2; rst_n = 1'b0; #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("async reset stall[%0d]", d), 64'(stO[d]), 64'd0);
      chk($sformatf("async reset pc_if_write[%0d]", d), 64'(pcO[d]), 64'd1);
      chk($sformatf("async reset r5[%0d]", d), 64'(rsD[d]), 64'd0);
      chk($sformatf("async reset stall_cycles[%0d]", d), 64'(stCnt[d]), 64'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    mClear();
    drain(1);

    // Random traffic over a small register window to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      setId($urandom_range(0, 9) < 8,
            $urandom_range(0, 7), $urandom_range(0, 3) != 0,
            $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      setWb($urandom_range(0, 1), $urandom_range(0, 7),
            ($urandom_range(0, 3) == 0) ? 32'h55 : $urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end
endmodule
